// File: rtl/seq_param_reduce.sv
// Multi-cycle AND/OR/XOR reduction of an nbits operand, folding chunk bits per cycle.
// Valid/ready request in, valid/ready single-bit result out; mode[2] inverts the result.
module seq_param_reduce #(
    parameter int unsigned nbits = 13,
    parameter int unsigned chunk = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] in_,
    input  logic [2:0]       mode,
    input  logic             in_val,
    output logic             in_rdy,
    output logic             out,
    output logic             out_val,
    input  logic             out_rdy
);

    localparam int unsigned nchunks = (nbits + chunk - 1) / chunk;
    localparam int unsigned PadW    = nchunks * chunk;
    localparam int unsigned IdxW    = (nchunks > 1) ? $clog2(nchunks) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(nchunks - 1);
    // Ones in the positions beyond nbits that only exist to fill the last chunk
    localparam logic [PadW-1:0] PadMask = ~({PadW{1'b1}} >> (PadW - nbits));

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t          r_state;
    logic [PadW-1:0] r_opnd;
    logic [1:0]      r_op;
    logic            r_inv;
    logic [IdxW-1:0] r_idx;
    logic            r_acc;
    logic            r_out;
    logic            r_out_val;
    logic            r_in_rdy;

    logic [chunk-1:0] w_bits;
    logic             w_acc_nxt;
    logic             w_in_is_and;

    assign w_in_is_and = (mode[1:0] == 2'b00);
    assign w_bits      = r_opnd[chunk-1:0];

    always_comb begin
        w_acc_nxt = r_acc;
        case (r_op)
            2'b00:   w_acc_nxt = r_acc & (&w_bits);
            2'b10:   w_acc_nxt = r_acc ^ (^w_bits);
            default: w_acc_nxt = r_acc | (|w_bits);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_opnd    <= '0;
            r_op      <= 2'b00;
            r_inv     <= 1'b0;
            r_idx     <= '0;
            r_acc     <= 1'b0;
            r_out     <= 1'b0;
            r_out_val <= 1'b0;
            r_in_rdy  <= 1'b1;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_val) begin
                        // Pad with the op identity so the filler bits never change the result
                        r_opnd   <= PadW'(in_) | (w_in_is_and ? PadMask : '0);
                        r_op     <= mode[1:0];
                        r_inv    <= mode[2];
                        r_idx    <= '0;
                        r_acc    <= w_in_is_and;
                        r_in_rdy <= 1'b0;
                        r_state  <= StBusy;
                    end
                end
                StBusy: begin
                    r_acc  <= w_acc_nxt;
                    r_opnd <= r_opnd >> chunk;
                    r_idx  <= r_idx + 1'b1;
                    if (r_idx == LastIdx) begin
                        r_out     <= w_acc_nxt ^ r_inv;
                        r_out_val <= 1'b1;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    if (out_rdy) begin
                        r_out_val <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_state   <= StIdle;
                    end
                end
                default: begin
                    r_out_val <= 1'b0;
                    r_in_rdy  <= 1'b1;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign in_rdy  = r_in_rdy;
    assign out     = r_out;
    assign out_val = r_out_val;

endmodule

// File: doc/seq_param_reduce.md
SEQ_PARAM_REDUCE -- requirements
Module: seq_param_reduce

Interface
REQ-001 The module SHALL have parameter nbits, default 13, giving the operand width.
REQ-002 The module SHALL have parameter chunk, default 4, giving the bits folded per cycle; legal values are 1 <= chunk <= nbits.
REQ-003 Derived constant nchunks SHALL equal ceil(nbits/chunk).
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset; clears all state immediately while low.
REQ-006 Port: in_  input  nbits  operand to reduce.
REQ-007 Port: mode  input  3  mode[1:0] op: 00 AND, 01 OR, 10 XOR, 11 treated as OR; mode[2] inverts the final result (NAND/NOR/XNOR).
REQ-008 Port: in_val  input  1  request valid.
REQ-009 Port: in_rdy  output  1  block can accept a request.
REQ-010 Port: out  output  1  reduction result.
REQ-011 Port: out_val  output  1  out is valid.
REQ-012 Port: out_rdy  input  1  consumer accepts the result.

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 In IDLE: in_rdy=1, out_val=0.
REQ-015 On an edge with in_val=1 and in_rdy=1, the block SHALL capture in_ and mode, clear the chunk index to 0, set the accumulator to the op identity (AND: 1; OR/XOR: 0), and move to BUSY.
REQ-016 In BUSY: in_rdy=0, out_val=0.
- Each edge folds bits [idx*chunk +: chunk] of the captured operand into the accumulator using the captured op.
- idx then increments by 1.
REQ-017 In a partial final chunk, bit positions >= nbits SHALL be padded with the op identity and SHALL NOT affect the result.
REQ-018 On the edge that folds chunk nchunks-1, the block SHALL:
- load out with the final accumulator value, XORed with the captured mode[2];
- move to DONE.
REQ-019 Latency: if accepted at edge k, out_val SHALL be 1 in the cycle following edge k+nchunks.
REQ-020 In DONE: out_val=1, in_rdy=0, and out SHALL stay stable until the transfer.
REQ-021 On an edge in DONE with out_rdy=1, the block SHALL move to IDLE; in_rdy=1 from the next cycle.
REQ-022 The block SHALL accept no new request while in BUSY or DONE.
- Changes to in_, mode or in_val in those states SHALL NOT affect the in-flight result.
REQ-023 When chunk=nbits, BUSY SHALL last exactly one cycle.
REQ-024 With out_rdy held at 1, back-to-back throughput SHALL be one result per nchunks+2 cycles.
REQ-025 out_rdy=0 in DONE SHALL hold the block in DONE indefinitely with no change to any output.
REQ-026 out SHALL retain its last value in IDLE and BUSY; only out_val qualifies it.

Reset
REQ-027 While reset=0, the block SHALL force state=IDLE, idx=0, accumulator=0, out=0, out_val=0 and in_rdy=1, regardless of clk.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation with no result delivered.
- After release, the first edge with in_val=1 SHALL start a fresh request.

Verification
REQ-029 nbits=4, chunk=4, mode=101 (NOR), in_=4'b0000 -> out_val=1 one cycle after BUSY, out=1; in_=4'b0010 -> out=0.
REQ-030 nbits=13, chunk=4, mode=000 (AND), in_=13'h1FFF -> 4 BUSY cycles, out=1; in_=13'h0FFF (MSB in the padded last chunk is 0) -> out=0.
REQ-031 nbits=13, chunk=4, mode=010 (XOR), in_=13'b1_0101_0101_0101 (seven ones) -> out=1; mode=110 (XNOR) on the same operand -> out=0.
REQ-032 Backpressure: hold out_rdy=0 for 5 cycles in DONE while toggling in_ and in_val -> out_val=1, out unchanged and in_rdy=0 throughout; after out_rdy=1, IDLE next cycle.
REQ-033 Reset mid-BUSY: drive reset=0 for 1 cycle during the 2nd BUSY cycle -> out=0, out_val=0 and in_rdy=1 immediately, with no result; a new request then completes with correct latency.
REQ-034 Random: 20 random 13-bit operands, random modes, random out_rdy stalls, chunk in {1,4,13} -> every out matches the golden reduction.
